// File: rtl/game_state_controller.sv
// Whack-A-Mole game-phase sequencer: IDLE -> RUN -> OVER -> IDLE, driven by
// start-button edges, with the countdown game timer and the end-message handshake.
module game_state_controller #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int GAME_SECONDS = 30
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       early_end,
    input  logic       fi_done,
    output logic       game_started,
    output logic       game_over,
    output logic [7:0] time_left,
    output logic       sec_tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_MAX  = PW'(TICK_DIV - 1);
    localparam logic [7:0]    TL_INIT = 8'(GAME_SECONDS);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t        state, state_n;
    logic [PW-1:0] prescaler, prescaler_n;
    logic [7:0]    time_left_n;
    logic          sec_tick_n, fi_armed, fi_armed_n, start_prev;
    logic          game_started_n, game_over_n;
    logic          start_edge;

    assign start_edge = start_btn & ~start_prev;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            prescaler    <= '0;
            time_left    <= TL_INIT;
            sec_tick     <= 1'b0;
            fi_armed     <= 1'b0;
            start_prev   <= 1'b1;  // a button held through reset must not start a game
            game_started <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            prescaler    <= prescaler_n;
            time_left    <= time_left_n;
            sec_tick     <= sec_tick_n;
            fi_armed     <= fi_armed_n;
            start_prev   <= start_btn;
            game_started <= game_started_n;
            game_over    <= game_over_n;
        end
    end

    always_comb begin
        state_n     = state;
        prescaler_n = prescaler;
        time_left_n = time_left;
        sec_tick_n  = 1'b0;
        fi_armed_n  = fi_armed;
        case (state)
            IDLE: begin
                time_left_n = TL_INIT;
                prescaler_n = '0;
                fi_armed_n  = 1'b0;
                if (start_edge && fi_done) state_n = RUN;
            end
            RUN: begin
                // early_end beats a coinciding tick wrap: time_left freezes as-is
                if (early_end) begin
                    state_n = OVER;
                end else if (prescaler == PS_MAX) begin
                    prescaler_n = '0;
                    sec_tick_n  = 1'b1;
                    if (time_left != 8'd0) time_left_n = time_left - 8'd1;
                    if (time_left <= 8'd1) state_n = OVER;
                end else begin
                    prescaler_n = prescaler + 1'b1;
                end
            end
            OVER: begin
                // fi_done must be seen low first so a stale ready cannot skip the end message
                if (!fi_done) fi_armed_n = 1'b1;
                if (fi_armed && fi_done && start_edge) begin
                    state_n     = IDLE;
                    time_left_n = TL_INIT;
                    fi_armed_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        game_started_n = (state_n != IDLE);
        game_over_n    = (state_n == OVER);
    end
endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller (TICK_DIV=4, GAME_SECONDS=3):
// a vector table for the main round plus hand sequences for corner cases.
module tb_game_state_controller;
    logic       clk = 1'b0;
    logic       reset, start_btn, early_end, fi_done;
    logic       game_started, game_over, sec_tick;
    logic [7:0] time_left;

    int checks = 0;
    int errors = 0;

    game_state_controller #(.TICK_DIV(4), .GAME_SECONDS(3)) dut (
        .CLOCK_50(clk), .reset(reset), .start_btn(start_btn), .early_end(early_end),
        .fi_done(fi_done), .game_started(game_started), .game_over(game_over),
        .time_left(time_left), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, sb, ee, fd;
        logic       gs, go;
        logic [7:0] tl;
        logic       st, chk_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic sb, logic ee, logic fd,
                                logic gs, logic go, logic [7:0] tl, logic st, logic chk_st);
        vec_t v;
        v.rst = rst; v.sb = sb; v.ee = ee; v.fd = fd;
        v.gs = gs; v.go = go; v.tl = tl; v.st = st; v.chk_st = chk_st;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // apply inputs, let one rising edge pass, settle away from the edge
    task automatic step(input logic r, input logic sb, input logic ee, input logic fd);
        reset = r; start_btn = sb; early_end = ee; fi_done = fd;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string name, input logic gs, input logic go,
                               input logic [7:0] tl, input logic st, input logic chk_st);
        chk({name, ".game_started"}, int'(game_started), int'(gs));
        chk({name, ".game_over"},    int'(game_over),    int'(go));
        chk({name, ".time_left"},    int'(time_left),    int'(tl));
        if (chk_st) chk({name, ".sec_tick"}, int'(sec_tick), int'(st));
    endtask

    initial begin
        reset = 1'b1; start_btn = 1'b0; early_end = 1'b0; fi_done = 1'b1;

        // reset with start held, then hold 10 more cycles: must stay IDLE
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 3, 0, 1));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 0, 1, 0, 0, 3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 1));   // early_end ignored in IDLE
        // start press -> RUN one edge later
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 3, 0, 1));
        for (int s = 2; s >= 1; s--) begin
            for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 1, 1, 0, 8'(s + 1), 0, 1));
            vecs.push_back(mk(0, 0, 0, 1, 1, 0, 8'(s), 1, 1));
        end
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0));   // 12 cycles after entry: OVER
        // OVER with fi_done held high: start presses ignored
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));   // arms
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 3, 0, 1));   // back to IDLE
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 0, 1));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].sb, vecs[i].ee, vecs[i].fd);
            expect_outs($sformatf("vec%0d", i), vecs[i].gs, vecs[i].go, vecs[i].tl,
                        vecs[i].st, vecs[i].chk_st);
        end

        // early_end coinciding with the tick wrap at time_left = 2
        step(0, 1, 0, 1); expect_outs("ee.entry", 1, 0, 3, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 1); expect_outs("ee.tick1", 1, 0, 2, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1); expect_outs("ee.wrap", 1, 1, 2, 0, 1);
        step(0, 0, 0, 1); expect_outs("ee.hold1", 1, 1, 2, 0, 1);
        step(0, 0, 0, 1); expect_outs("ee.hold2", 1, 1, 2, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 1); expect_outs("ee.exit", 0, 0, 3, 0, 1);
        step(0, 0, 0, 1);

        // start press while display busy is dropped, must be repeated
        step(0, 1, 0, 0); expect_outs("busy.press", 0, 0, 3, 0, 1);
        step(0, 1, 0, 1); expect_outs("busy.held", 0, 0, 3, 0, 1);
        step(0, 0, 0, 1); expect_outs("busy.rel", 0, 0, 3, 0, 1);
        step(0, 1, 0, 1); expect_outs("busy.repress", 1, 0, 3, 0, 1);

        // run down to time_left = 1, then reset mid-RUN
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        expect_outs("rst.tl1", 1, 0, 1, 1, 1);
        step(0, 0, 0, 1); expect_outs("rst.pre", 1, 0, 1, 0, 1);
        step(1, 0, 0, 1); expect_outs("rst.mid", 0, 0, 3, 0, 1);
        step(0, 0, 0, 1); expect_outs("rst.after", 0, 0, 3, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
